// File: rtl/z_core_pkg.sv
// rtl/z_core_pkg.sv - shared encodings and opcode decode for the Z-Core control unit
package z_core_pkg;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_DECODE,
    ST_EXECUTE,
    ST_MEM,
    ST_WRITEBACK,
    ST_TRAP
  } state_e;

  localparam logic [1:0] PC_PLUS4  = 2'd0;
  localparam logic [1:0] PC_ALU    = 2'd1;
  localparam logic [1:0] PC_BRANCH = 2'd2;

  localparam logic [1:0] A_RS1  = 2'd0;
  localparam logic [1:0] A_PC   = 2'd1;
  localparam logic [1:0] A_ZERO = 2'd2;

  localparam logic B_RS2 = 1'b0;
  localparam logic B_IMM = 1'b1;

  localparam logic [1:0] WB_ALU = 2'd0;
  localparam logic [1:0] WB_MEM = 2'd1;
  localparam logic [1:0] WB_PC4 = 2'd2;

  localparam logic [1:0] CAUSE_NONE    = 2'd0;
  localparam logic [1:0] CAUSE_ILLEGAL = 2'd1;
  localparam logic [1:0] CAUSE_TIMEOUT = 2'd2;

  // funct3 010/011 have no branch meaning in RV32I
  function automatic logic is_legal(input logic [6:0] op, input logic [2:0] f3);
    logic ok;
    ok = 1'b0;
    case (op)
      OP_R, OP_I, OP_LOAD, OP_STORE, OP_JALR, OP_JAL, OP_LUI, OP_AUIPC: ok = 1'b1;
      OP_BRANCH: ok = (f3 != 3'b010) && (f3 != 3'b011);
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/z_core_mem_timer.sv
// rtl/z_core_mem_timer.sv - wait-cycle counter flagging a memory request that has gone unanswered
module z_core_mem_timer #(
  parameter int TIMEOUT_CYC = 255
) (
  input  logic clk,
  input  logic rstn,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int W = $clog2(TIMEOUT_CYC + 1);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  // Flags the waiting cycle that would bring the count to TIMEOUT_CYC
  assign expired = en && (cnt_q == W'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/z_core_control_unit.sv
// rtl/z_core_control_unit.sv - multi-cycle RV32I sequencer driving datapath selects, enables and memory handshake
module z_core_control_unit
  import z_core_pkg::*;
#(
  parameter int TIMEOUT_CYC = 255
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic [6:0]  opcode,
  input  logic [2:0]  funct3,
  input  logic        branch_taken,
  input  logic        mem_ready,
  output logic        mem_req,
  output logic        mem_we,
  output logic        addr_sel,
  output logic        ir_we,
  output logic        pc_we,
  output logic [1:0]  pc_src,
  output logic [1:0]  alu_a_sel,
  output logic        alu_b_sel,
  output logic        rf_we,
  output logic [1:0]  wb_sel,
  output logic        trap,
  output logic [1:0]  trap_cause,
  output logic [31:0] instret
);

  state_e      state_q, state_d;
  logic [1:0]  cause_q, cause_d;
  logic [31:0] instret_q, instret_d;
  logic        waiting, expired;
  logic [1:0]  op_a_sel;
  logic        op_b_sel;
  logic        is_jump;

  assign waiting = (state_q == ST_FETCH) || (state_q == ST_MEM);
  assign is_jump = (opcode == OP_JAL) || (opcode == OP_JALR);

  z_core_mem_timer #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_mem_timer (
    .clk     (clk),
    .rstn    (rstn),
    .clr     (!waiting || mem_ready),
    .en      (waiting && !mem_ready),
    .expired (expired)
  );

  always_comb begin
    op_a_sel = A_RS1;
    op_b_sel = B_IMM;
    case (opcode)
      OP_R, OP_BRANCH:  op_b_sel = B_RS2;
      OP_LUI:           op_a_sel = A_ZERO;
      OP_AUIPC, OP_JAL: op_a_sel = A_PC;
      default:          op_a_sel = A_RS1;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    cause_d   = cause_q;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    addr_sel  = 1'b0;
    ir_we     = 1'b0;
    pc_we     = 1'b0;
    pc_src    = PC_PLUS4;
    alu_a_sel = A_RS1;
    alu_b_sel = B_RS2;
    rf_we     = 1'b0;
    wb_sel    = WB_ALU;
    case (state_q)
      ST_IDLE: state_d = ST_FETCH;
      ST_FETCH: begin
        mem_req = 1'b1;
        if (mem_ready) begin
          ir_we   = 1'b1;
          state_d = ST_DECODE;
        end else if (expired) begin
          state_d = ST_TRAP;
          cause_d = CAUSE_TIMEOUT;
        end
      end
      ST_DECODE: begin
        if (is_legal(opcode, funct3)) begin
          state_d = ST_EXECUTE;
        end else begin
          state_d = ST_TRAP;
          cause_d = CAUSE_ILLEGAL;
        end
      end
      ST_EXECUTE: begin
        alu_a_sel = op_a_sel;
        alu_b_sel = op_b_sel;
        if (opcode == OP_BRANCH) begin
          pc_we   = 1'b1;
          pc_src  = branch_taken ? PC_BRANCH : PC_PLUS4;
          state_d = ST_FETCH;
        end else if ((opcode == OP_LOAD) || (opcode == OP_STORE)) begin
          state_d = ST_MEM;
        end else begin
          state_d = ST_WRITEBACK;
        end
      end
      ST_MEM: begin
        mem_req   = 1'b1;
        addr_sel  = 1'b1;
        mem_we    = (opcode == OP_STORE);
        alu_a_sel = op_a_sel;
        alu_b_sel = op_b_sel;
        if (mem_ready) begin
          if (opcode == OP_STORE) begin
            pc_we   = 1'b1;
            state_d = ST_FETCH;
          end else begin
            state_d = ST_WRITEBACK;
          end
        end else if (expired) begin
          state_d = ST_TRAP;
          cause_d = CAUSE_TIMEOUT;
        end
      end
      ST_WRITEBACK: begin
        rf_we   = 1'b1;
        pc_we   = 1'b1;
        pc_src  = is_jump ? PC_ALU : PC_PLUS4;
        wb_sel  = (opcode == OP_LOAD) ? WB_MEM : (is_jump ? WB_PC4 : WB_ALU);
        state_d = ST_FETCH;
      end
      ST_TRAP: state_d = ST_TRAP;
      default: state_d = ST_IDLE;
    endcase
  end

  // Every retiring path asserts pc_we, and TRAP never does
  always_comb begin
    instret_d = instret_q + {31'b0, pc_we};
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= ST_IDLE;
      cause_q   <= CAUSE_NONE;
      instret_q <= '0;
    end else begin
      state_q   <= state_d;
      cause_q   <= cause_d;
      instret_q <= instret_d;
    end
  end

  assign trap       = (state_q == ST_TRAP);
  assign trap_cause = cause_q;
  assign instret    = instret_q;

endmodule

// File: tb/tb_z_core_control_unit.sv
// tb/tb_z_core_control_unit.sv - scoreboard bench for the Z-Core control unit
module tb_z_core_control_unit;
  import z_core_pkg::*;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic [6:0]  opcode = 7'd0;
  logic [2:0]  funct3 = 3'd0;
  logic        branch_taken = 1'b0;
  logic        mem_ready = 1'b0;
  logic        mem_req, mem_we, addr_sel, ir_we, pc_we, alu_b_sel, rf_we, trap;
  logic [1:0]  pc_src, alu_a_sel, wb_sel, trap_cause;
  logic [31:0] instret;

  always #5 clk = ~clk;

  z_core_control_unit #(.TIMEOUT_CYC(4)) dut (
    .clk(clk), .rstn(rstn), .opcode(opcode), .funct3(funct3),
    .branch_taken(branch_taken), .mem_ready(mem_ready),
    .mem_req(mem_req), .mem_we(mem_we), .addr_sel(addr_sel), .ir_we(ir_we),
    .pc_we(pc_we), .pc_src(pc_src), .alu_a_sel(alu_a_sel), .alu_b_sel(alu_b_sel),
    .rf_we(rf_we), .wb_sel(wb_sel), .trap(trap), .trap_cause(trap_cause),
    .instret(instret)
  );

  typedef struct {
    bit          retire;
    int          cyc;
    logic [1:0]  pc_src;
    logic        rf_we;
    logic [1:0]  wb_sel;
    logic [31:0] instret;
  } ev_t;

  ev_t exp_q[$];
  int  checks = 0;
  int  failures = 0;
  int  cyc_abs = 0;
  int  base = 0;
  int  fetch_wait = 0;
  int  mem_wait = 0;
  int  n_mem_addr = 0, n_req = 0, n_rf = 0, n_mem_alu = 0;
  int  s_mem_addr, s_req, s_rf, s_mem_alu;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic push_ev(input bit r, input int c, input logic [1:0] ps, input logic rf,
                         input logic [1:0] wb, input logic [31:0] ir);
    ev_t e;
    e.retire = r; e.cyc = c; e.pc_src = ps; e.rf_we = rf; e.wb_sel = wb; e.instret = ir;
    exp_q.push_back(e);
  endtask

  always @(posedge clk) cyc_abs = cyc_abs + 1;

  // Memory responder: answers after fetch_wait / mem_wait unanswered cycles
  always begin : responder
    int wcnt;
    wcnt = 0;
    forever begin
      @(posedge clk); #1;
      if (mem_req) begin
        if (wcnt >= (addr_sel ? mem_wait : fetch_wait)) begin
          mem_ready = 1'b1; wcnt = 0;
        end else begin
          mem_ready = 1'b0; wcnt++;
        end
      end else begin
        mem_ready = 1'b0; wcnt = 0;
      end
    end
  end

  // Monitor: pops one expectation per ir_we / pc_we / rf_we cycle
  always @(negedge clk) begin
    int c;
    ev_t e;
    c = cyc_abs - base;
    if (rstn) begin
      if (mem_req && addr_sel) n_mem_addr++;
      if (mem_req) n_req++;
      if (rf_we) n_rf++;
      if (mem_req && addr_sel && alu_a_sel == A_RS1 && alu_b_sel == B_IMM) n_mem_alu++;
      if (ir_we || pc_we || rf_we) begin
        if (exp_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_event cyc=%0d: actual ir_we=%b pc_we=%b rf_we=%b required none",
                   c, ir_we, pc_we, rf_we);
        end else begin
          e = exp_q.pop_front();
          if (!e.retire)
            check($sformatf("fetch@%0d", e.cyc),
                  {c[15:0], ir_we, mem_req, addr_sel, pc_we, rf_we},
                  {e.cyc[15:0], 5'b11000});
          else
            check($sformatf("retire@%0d", e.cyc),
                  {c[15:0], ir_we, pc_we, pc_src, rf_we, (e.rf_we ? wb_sel : 2'b00), instret},
                  {e.cyc[15:0], 1'b0, 1'b1, e.pc_src, e.rf_we, e.wb_sel, e.instret});
        end
      end
    end
  end

  task automatic wait_cyc(input int n);
    int guard;
    guard = 0;
    while ((cyc_abs - base) < n && guard < 200) begin
      @(posedge clk); #1;
      guard++;
    end
  endtask

  task automatic start_test(input logic [6:0] op, input logic [2:0] f3, input logic bt,
                            input int fw, input int mw);
    rstn = 1'b0;
    opcode = op; funct3 = f3; branch_taken = bt; fetch_wait = fw; mem_wait = mw;
    @(posedge clk); #1;
    check("leftover_expectations", exp_q.size(), 0);
    exp_q.delete();
    s_mem_addr = n_mem_addr; s_req = n_req; s_rf = n_rf; s_mem_alu = n_mem_alu;
    base = cyc_abs;
    rstn = 1'b1;
  endtask

  initial begin
    #12;
    check("reset_outputs",
          {mem_req, mem_we, addr_sel, ir_we, pc_we, pc_src, alu_a_sel, alu_b_sel,
           rf_we, wb_sel, trap, trap_cause, instret}, 0);

    // ADDI back to back, zero-wait memory
    start_test(OP_I, 3'b000, 1'b0, 0, 0);
    push_ev(0, 1, 0, 0, 0, 0); push_ev(1, 4, PC_PLUS4, 1, WB_ALU, 0);
    push_ev(0, 5, 0, 0, 0, 0); push_ev(1, 8, PC_PLUS4, 1, WB_ALU, 1);
    wait_cyc(9);
    check("addi_instret", instret, 2);

    // LUI operand selects
    start_test(OP_LUI, 3'b000, 1'b0, 0, 0);
    push_ev(0, 1, 0, 0, 0, 0); push_ev(1, 4, PC_PLUS4, 1, WB_ALU, 0);
    wait_cyc(3);
    check("lui_alu_sel", {alu_a_sel, alu_b_sel}, {A_ZERO, B_IMM});
    wait_cyc(5);

    // JAL then JALR
    start_test(OP_JAL, 3'b000, 1'b0, 0, 0);
    push_ev(0, 1, 0, 0, 0, 0); push_ev(1, 4, PC_ALU, 1, WB_PC4, 0);
    push_ev(0, 5, 0, 0, 0, 0); push_ev(1, 8, PC_ALU, 1, WB_PC4, 1);
    wait_cyc(3);
    check("jal_alu_sel", {alu_a_sel, alu_b_sel}, {A_PC, B_IMM});
    wait_cyc(5);
    opcode = OP_JALR;
    wait_cyc(7);
    check("jalr_alu_sel", {alu_a_sel, alu_b_sel}, {A_RS1, B_IMM});
    wait_cyc(9);

    // BEQ taken then not taken
    start_test(OP_BRANCH, 3'b000, 1'b1, 0, 0);
    push_ev(0, 1, 0, 0, 0, 0); push_ev(1, 3, PC_BRANCH, 0, 0, 0);
    push_ev(0, 4, 0, 0, 0, 0); push_ev(1, 6, PC_PLUS4, 0, 0, 1);
    wait_cyc(3);
    check("beq_alu_sel", {alu_a_sel, alu_b_sel}, {A_RS1, B_RS2});
    wait_cyc(4);
    branch_taken = 1'b0;
    wait_cyc(7);
    check("beq_no_rf_we", n_rf - s_rf, 0);

    // LW with 3 wait states
    start_test(OP_LOAD, 3'b010, 1'b0, 0, 3);
    push_ev(0, 1, 0, 0, 0, 0); push_ev(1, 8, PC_PLUS4, 1, WB_MEM, 0);
    wait_cyc(9);
    check("lw_mem_hold", n_mem_addr - s_mem_addr, 4);
    check("lw_mem_alu_sel", n_mem_alu - s_mem_alu, 4);
    check("lw_rf_we_once", n_rf - s_rf, 1);

    // SW, then reset in the middle of the second SW's MEM wait
    start_test(OP_STORE, 3'b010, 1'b0, 0, 1);
    push_ev(0, 1, 0, 0, 0, 0); push_ev(1, 5, PC_PLUS4, 0, 0, 0);
    push_ev(0, 6, 0, 0, 0, 0);
    wait_cyc(9);
    check("sw_mem_active", {mem_req, mem_we, addr_sel, instret}, {3'b111, 32'd1});
    #2 rstn = 1'b0;
    #1 check("sw_reset_drop", {mem_req, mem_we, addr_sel, instret}, 0);
    start_test(OP_STORE, 3'b010, 1'b0, 0, 1);
    push_ev(0, 1, 0, 0, 0, 0); push_ev(1, 5, PC_PLUS4, 0, 0, 0);
    wait_cyc(6);

    // Illegal opcode traps after DECODE and stays quiet
    start_test(7'b1111111, 3'b000, 1'b0, 0, 0);
    push_ev(0, 1, 0, 0, 0, 0);
    wait_cyc(2);
    check("illegal_pre_trap", {trap, trap_cause}, 0);
    wait_cyc(3);
    check("illegal_trap", {trap, trap_cause}, {1'b1, CAUSE_ILLEGAL});
    s_req = n_req;
    wait_cyc(23);
    check("illegal_no_mem_req", n_req - s_req, 0);
    check("illegal_frozen", {trap, trap_cause, instret}, {1'b1, CAUSE_ILLEGAL, 32'd0});

    // B-type with reserved funct3
    start_test(OP_BRANCH, 3'b010, 1'b0, 0, 0);
    push_ev(0, 1, 0, 0, 0, 0);
    wait_cyc(3);
    check("bad_branch_trap", {trap, trap_cause}, {1'b1, CAUSE_ILLEGAL});
    wait_cyc(4);

    // Fetch never answered: trap after 4 waiting cycles
    start_test(OP_I, 3'b000, 1'b0, 100, 0);
    wait_cyc(4);
    check("timeout_waiting", {mem_req, trap}, 2'b10);
    wait_cyc(5);
    check("timeout_trap", {mem_req, trap, trap_cause}, {1'b0, 1'b1, CAUSE_TIMEOUT});
    wait_cyc(6);

    // Answer arrives on the 4th waiting cycle: no trap
    start_test(OP_I, 3'b000, 1'b0, 3, 0);
    push_ev(0, 4, 0, 0, 0, 0); push_ev(1, 7, PC_PLUS4, 1, WB_ALU, 0);
    wait_cyc(8);
    check("ready_at_limit", {trap, trap_cause, instret}, {1'b0, CAUSE_NONE, 32'd1});

    check("final_leftover", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
